// File: rtl/serial_frame_deserializer.sv
// -----------------------------------------------------------------------------
// serial_frame_deserializer
//
// Turns the serial bit stream from the 4-stage shift chain into parallel
// words. The receiver hunts for a sync pattern, then collects WIDTH data bits
// and one even-parity bit. A good word is presented on a registered output
// with a valid/ready handshake. Parity failures and dropped frames are
// reported as single-cycle pulses.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   bit_in     in   serial data bit, qualified by bit_valid
//   bit_valid  in   bit_in carries a bit this cycle
//   word_ready in   consumer takes word_out while word_valid=1
//   word_out   out  last good received word (registered)
//   word_valid out  word_out holds an unconsumed word
//   parity_err out  one-cycle pulse: frame discarded on parity failure
//   overrun    out  one-cycle pulse: good frame dropped, output occupied
//   in_frame   out  high while collecting data or parity
// -----------------------------------------------------------------------------
module serial_frame_deserializer #(
    parameter int                  WIDTH        = 8,
    parameter int                  SYNC_LEN     = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1011,
    parameter bit                  MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             parity_err,
    output logic             overrun,
    output logic             in_frame
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Even parity check: result is 1 when the frame carries an odd number of ones.
    function automatic logic frame_parity_fail(input logic [WIDTH-1:0] data,
                                               input logic             par);
        return ^{data, par};
    endfunction

    state_t              state_r, state_s;
    logic [SYNC_LEN-1:0] hist_r, hist_s, hist_shift_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [WIDTH-1:0]    data_r, data_s, data_shift_s;
    logic [WIDTH-1:0]    word_out_r, word_out_s;
    logic                word_valid_r, word_valid_s;
    logic                parity_err_r, parity_err_s;
    logic                overrun_r, overrun_s;
    logic                in_frame_r;

    assign word_out   = word_out_r;
    assign word_valid = word_valid_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;
    assign in_frame   = in_frame_r;

    // Shifted views of the sync history and the data register for this bit.
    always_comb begin
        hist_shift_s = {hist_r[SYNC_LEN-2:0], bit_in};
        if (MSB_FIRST) begin
            data_shift_s = {data_r[WIDTH-2:0], bit_in};
        end else begin
            data_shift_s = {bit_in, data_r[WIDTH-1:1]};
        end
    end

    // Next-state, datapath and output-handshake logic.
    always_comb begin
        state_s      = state_r;
        hist_s       = hist_r;
        cnt_s        = cnt_r;
        data_s       = data_r;
        word_out_s   = word_out_r;
        // An accepted word frees the output unless a new load overrides below.
        word_valid_s = word_valid_r & ~word_ready;
        parity_err_s = 1'b0;
        overrun_s    = 1'b0;

        case (state_r)
            ST_HUNT: begin
                if (bit_valid) begin
                    hist_s = hist_shift_s;
                    if (hist_shift_s == SYNC_PATTERN) begin
                        state_s = ST_DATA;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        state_s = ST_HUNT;
                    end
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_DATA: begin
                if (bit_valid) begin
                    data_s = data_shift_s;
                    cnt_s  = cnt_r + CW'(1);
                    if (cnt_r == LAST_IDX) begin
                        state_s = ST_PARITY;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_valid) begin
                    // History is cleared so data bits never contribute to sync.
                    state_s = ST_HUNT;
                    hist_s  = {SYNC_LEN{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    if (frame_parity_fail(data_r, bit_in)) begin
                        parity_err_s = 1'b1;
                    end else if (!word_valid_r || word_ready) begin
                        word_out_s   = data_r;
                        word_valid_s = 1'b1;
                    end else begin
                        overrun_s = 1'b1;
                    end
                end else begin
                    state_s = ST_PARITY;
                end
            end
            default: begin
                state_s = ST_HUNT;
                hist_s  = {SYNC_LEN{1'b0}};
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_HUNT;
            hist_r       <= {SYNC_LEN{1'b0}};
            cnt_r        <= {CW{1'b0}};
            data_r       <= {WIDTH{1'b0}};
            word_out_r   <= {WIDTH{1'b0}};
            word_valid_r <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
            in_frame_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            hist_r       <= hist_s;
            cnt_r        <= cnt_s;
            data_r       <= data_s;
            word_out_r   <= word_out_s;
            word_valid_r <= word_valid_s;
            parity_err_r <= parity_err_s;
            overrun_r    <= overrun_s;
            in_frame_r   <= (state_s != ST_HUNT);
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// -----------------------------------------------------------------------------
// Directed bench for serial_frame_deserializer. Two instances share the input
// stream: one MSB-first (main checks) and one LSB-first (bit order checks).
// -----------------------------------------------------------------------------
module tb_serial_frame_deserializer;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       word_ready;
    logic [7:0] word_out;
    logic       word_valid;
    logic       parity_err;
    logic       overrun;
    logic       in_frame;
    logic [7:0] l_word_out;
    logic       l_word_valid;
    logic       l_parity_err;
    logic       l_overrun;
    logic       l_in_frame;

    int checks;
    int errors;

    serial_frame_deserializer #(
        .WIDTH(8), .SYNC_LEN(4), .SYNC_PATTERN(4'b1011), .MSB_FIRST(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_ready(word_ready), .word_out(word_out), .word_valid(word_valid),
        .parity_err(parity_err), .overrun(overrun), .in_frame(in_frame)
    );

    serial_frame_deserializer #(
        .WIDTH(8), .SYNC_LEN(4), .SYNC_PATTERN(4'b1011), .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_ready(word_ready), .word_out(l_word_out), .word_valid(l_word_valid),
        .parity_err(l_parity_err), .overrun(l_overrun), .in_frame(l_in_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One valid bit on the next rising edge; returns 1 time unit after it.
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        send_sync();
        send_byte(d);
        send_bit(p);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL reset_word_out got %h want 00", word_out); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
        checks++; if (parity_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", parity_err, overrun); end
        checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL reset_in_frame got %b want 0", in_frame); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send_sync();
        checks++; if (in_frame !== 1'b1) begin errors++; $display("FAIL basic_in_frame_after_sync got %b want 1", in_frame); end
        send_byte(8'hA5);
        send_bit(1'b0);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", word_valid); end
        checks++; if (word_out !== 8'hA5) begin errors++; $display("FAIL basic_word got %h want a5", word_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr got %b want 0", parity_err); end
        checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL basic_in_frame_end got %b want 0", in_frame); end
        idle(1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", word_valid); end
    endtask

    task automatic test_parity_err();
        word_ready = 1'b1;
        send_frame(8'h3C, 1'b1);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL perr_pulse got %b want 1", parity_err); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL perr_valid got %b want 0", word_valid); end
        checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL perr_in_frame got %b want 0", in_frame); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL perr_no_overrun got %b want 0", overrun); end
        idle(1);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL perr_one_cycle got %b want 0", parity_err); end
        send_frame(8'h0F, 1'b0);
        checks++; if (word_out !== 8'h0F || word_valid !== 1'b1) begin errors++; $display("FAIL perr_recover got %h/%b want 0f/1", word_out, word_valid); end
        idle(1);
    endtask

    task automatic test_overrun();
        word_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        checks++; if (word_out !== 8'h11 || word_valid !== 1'b1) begin errors++; $display("FAIL ovr_first got %h/%b want 11/1", word_out, word_valid); end
        idle(3);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold got %b want 1", word_valid); end
        send_frame(8'h22, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", overrun); end
        checks++; if (word_out !== 8'h11 || word_valid !== 1'b1) begin errors++; $display("FAIL ovr_keep got %h/%b want 11/1", word_out, word_valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ovr_no_perr got %b want 0", parity_err); end
        idle(1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got %b want 0", overrun); end
        word_ready = 1'b1;
        idle(1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ovr_release got %b want 0", word_valid); end
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        send_sync();
        send_byte(8'h33);
        @(negedge clk);
        bit_in     = 1'b0;
        bit_valid  = 1'b1;
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        checks++; if (word_out !== 8'h33 || word_valid !== 1'b1) begin errors++; $display("FAIL b2b_load got %h/%b want 33/1", word_out, word_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %b want 0", overrun); end
        idle(1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", word_valid); end
    endtask

    task automatic test_gapped_sync();
        logic [5:0] stream;
        logic [7:0] d;
        stream = 6'b101011;
        d      = 8'hC3;
        word_ready = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            send_bit(stream[i]);
            idle(1);
        end
        checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL gap_no_early_match got %b want 0", in_frame); end
        send_bit(stream[0]);
        idle(1);
        checks++; if (in_frame !== 1'b1) begin errors++; $display("FAIL gap_match_6th got %b want 1", in_frame); end
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            idle(1);
        end
        checks++; if (word_valid !== 1'b0 || in_frame !== 1'b1) begin errors++; $display("FAIL gap_wait_parity got %b/%b want 0/1", word_valid, in_frame); end
        send_bit(1'b0);
        checks++; if (word_out !== 8'hC3 || word_valid !== 1'b1) begin errors++; $display("FAIL gap_word got %h/%b want c3/1", word_out, word_valid); end
        idle(1);
    endtask

    task automatic test_reset_mid_frame();
        word_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (word_out !== 8'h00 || word_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_word got %h/%b want 00/0", word_out, word_valid); end
        checks++; if (in_frame !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %b%b%b want 000", in_frame, parity_err, overrun); end
        word_ready = 1'b1;
        send_frame(8'h5A, 1'b0);
        checks++; if (word_out !== 8'h5A || word_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_msb got %h/%b want 5a/1", word_out, word_valid); end
        checks++; if (l_word_out !== 8'h5A || l_word_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_lsb got %h/%b want 5a/1", l_word_out, l_word_valid); end
        send_frame(8'h12, 1'b0);
        checks++; if (word_out !== 8'h12) begin errors++; $display("FAIL order_msb got %h want 12", word_out); end
        checks++; if (l_word_out !== 8'h48) begin errors++; $display("FAIL order_lsb got %h want 48", l_word_out); end
        idle(1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        test_reset();
        test_basic();
        test_parity_err();
        test_overrun();
        test_back_to_back();
        test_gapped_sync();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
- Consumes the serial bit stream leaving the 4-stage serial-in/serial-out shift chain (`siso_design.q`).
- Hunts for a sync pattern, collects WIDTH data bits plus one even-parity bit, and presents the word on a registered parallel output with a valid/ready handshake.
- Reports parity errors and overruns as single-cycle pulses.
- Sits between the serial chain and any parallel consumer.

Parameters:
- WIDTH, 8, number of data bits per frame (2..32).
- SYNC_LEN, 4, length of the sync pattern in bits (2..8).
- SYNC_PATTERN, 4'b1011, sync pattern; the MSB is received first.
- MSB_FIRST, 1, 1: first data bit lands in word_out[WIDTH-1]; 0: first data bit lands in word_out[0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for the current cycle.
- word_ready  input  1  consumer accepts word_out when word_valid=1.
- word_out  output  WIDTH  last good received word (registered).
- word_valid  output  1  word_out holds an unconsumed word.
- parity_err  output  1  one-cycle pulse: frame discarded on parity failure.
- overrun  output  1  one-cycle pulse: good frame dropped because the output was occupied.
- in_frame  output  1  high while state is DATA or PARITY.

Behaviour:
- Reset (rst=1 at an edge): state HUNT, sync history cleared to 0, bit counter 0, word_out=0, word_valid=0, parity_err=0, overrun=0, in_frame=0. Reset overrides all other activity, including mid-frame.
- bit_valid=0: no change to FSM, history, counter or shift data. The output handshake still operates, and pulses still clear.
- HUNT:
  - On each bit_valid, shift bit_in into the SYNC_LEN-bit history (newest bit in the LSB).
  - When the updated history equals SYNC_PATTERN, go to DATA with counter=0.
  - Matching uses a sliding window, so overlapping prefixes must be found (e.g. stream 1,0,1,0,1,1 matches on the 6th bit).
- DATA:
  - Each bit_valid shifts bit_in into the data register per MSB_FIRST and increments the counter.
  - After the WIDTH-th bit, go to PARITY.
- PARITY: on bit_valid, compute the XOR of the WIDTH data bits and the parity bit.
  - XOR=1: pulse parity_err on the next cycle, discard the frame, word_out unchanged.
  - XOR=0, and the output is free or being freed this edge (word_valid=0, or word_valid&word_ready=1): load word_out; word_valid=1 from the next cycle.
  - XOR=0, and word_valid=1 with word_ready=0: pulse overrun; word_out and word_valid unchanged; frame dropped.
  - In all three cases, return to HUNT with the history cleared to 0, so data bits are never reused for sync.
- Latency: word_valid rises on the first cycle after the edge that samples the parity bit.
- Output handshake:
  - word_valid stays high until an edge with word_ready=1.
  - Acceptance and a new load on the same edge: the load wins, word_out takes the new word, and word_valid stays 1.
  - word_ready while word_valid=0 is ignored.
- Event priority:
  - parity_err and overrun never assert together; a bad-parity frame never causes overrun.
  - Both pulses last exactly one cycle.
- Widths: the counter is sized ceil(log2(WIDTH+1)). The counter does not wrap within a frame.
- in_frame is a registered version of (state != HUNT).

Test Plan:
- Basic frame: bits 1,0,1,1, data 0xA5 MSB-first, parity 0; word_ready=1 -> word_out=0xA5, word_valid=1 for one cycle starting the cycle after the parity bit; parity_err=0.
- Parity error: sync 1011, data 0x3C, parity 1 -> parity_err pulses once; word_valid stays 0; in_frame falls. A following good frame with 0x0F and parity 0 -> word_out=0x0F.
- Backpressure and overrun: word_ready=0, frame 0x11 then frame 0x22 -> after the first frame word_valid=1 with 0x11; after the second, overrun pulses and word_out stays 0x11. Raise word_ready -> word_valid drops the next cycle.
- Simultaneous accept and load: word_valid=1 holding 0x11, word_ready=1 on the same edge as the parity bit of frame 0x33 -> word_out=0x33, word_valid stays 1, no overrun.
- Gapped bits and overlapping sync: stream 1,0,1,0,1,1 with bit_valid=0 between every bit, then data 0xC3 with parity 0 -> the sync match occurs on the 6th valid bit; word_out=0xC3.
- Reset mid-frame: sync plus 4 data bits, then rst for one cycle -> all outputs 0, in_frame=0. A full frame 0x5A with parity 0 -> word_out=0x5A. Repeat with MSB_FIRST=0: the same bit stream yields the bit-reversed word 0x5A.
